// File: rtl/simp_pipe_csa_n_pkg.sv
// ----------------------------------------------------------------------------
// simp_pipe_csa_n_pkg
// Shared DPE parameters, operand types and constant helpers used to size the
// carry-save reduction tree of simp_pipe_csa_n.
//   INPUT_VEC_LEN : operands summed per cycle (>= 1)
//   WIDTH         : operand / result width
//   operand_t     : WIDTH-bit unsigned operand
//   cs_pair_t     : carry-save pair (sum, carry) held in pipeline bank A
// ----------------------------------------------------------------------------
package simp_pipe_csa_n_pkg;

    localparam int INPUT_VEC_LEN = 8;
    localparam int WIDTH         = 16;

    typedef logic [WIDTH-1:0] operand_t;

    typedef struct packed {
        operand_t sum;
        operand_t carry;
    } cs_pair_t;

    // One tree level maps n operands to 2 per full group of three, plus the
    // 1 or 2 leftovers that pass straight through.
    function automatic int next_count(input int n);
        return 2 * (n / 3) + (n % 3);
    endfunction

    // Operand count present at a given tree level (level 0 = the inputs).
    function automatic int level_count(input int n, input int lvl);
        int c;
        c = n;
        for (int i = 0; i < lvl; i++) begin
            c = next_count(c);
        end
        return c;
    endfunction

    // Number of compressor levels needed to reach two (or fewer) operands.
    function automatic int num_levels(input int n);
        int c;
        int l;
        c = n;
        l = 0;
        while (c > 2) begin
            c = next_count(c);
            l++;
        end
        return l;
    endfunction

    // Start index of a level inside the flat node array holding every level.
    function automatic int level_base(input int n, input int lvl);
        int b;
        b = 0;
        for (int i = 0; i < lvl; i++) begin
            b += level_count(n, i);
        end
        return b;
    endfunction

endpackage

// File: rtl/simp_pipe_csa_n_if.sv
// ----------------------------------------------------------------------------
// simp_pipe_csa_n_if
// Data bus of the multi-operand adder.
//   in : packed operand vector [NUM_OPS-1:0][WIDTH-1:0], unsigned
//   s  : registered sum, modulo 2^WIDTH
// Modports: master drives in / reads s; slave (the adder) the reverse.
// ----------------------------------------------------------------------------
interface simp_pipe_csa_n_if
    import simp_pipe_csa_n_pkg::*;
#(
    parameter int NUM_OPS = INPUT_VEC_LEN
);

    logic [NUM_OPS-1:0][WIDTH-1:0] in;
    operand_t                      s;

    modport master (output in, input  s);
    modport slave  (input  in, output s);

endinterface

// File: rtl/simp_pipe_csa_n_csa_3to2.sv
// ----------------------------------------------------------------------------
// csa_3to2
// Word-wide 3:2 carry-save compressor.
//   a, b, c : WIDTH-bit addends
//   sum     : a ^ b ^ c
//   carry   : majority(a, b, c) << 1, truncated to WIDTH bits
// sum + carry == a + b + c (mod 2^WIDTH).
// ----------------------------------------------------------------------------
module csa_3to2
    import simp_pipe_csa_n_pkg::*;
(
    input  operand_t a,
    input  operand_t b,
    input  operand_t c,
    output operand_t sum,
    output operand_t carry
);

    assign sum = a ^ b ^ c;

    // The majority of the top bit would land at bit WIDTH, so only the lower
    // WIDTH-1 majority bits are formed and shifted up.
    assign carry = {(a[WIDTH-2:0] & b[WIDTH-2:0]) |
                    (a[WIDTH-2:0] & c[WIDTH-2:0]) |
                    (b[WIDTH-2:0] & c[WIDTH-2:0]), 1'b0};

endmodule

// File: rtl/simp_pipe_csa_n.sv
// ----------------------------------------------------------------------------
// simp_pipe_csa_n
// Two-stage pipelined multi-operand adder.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears bank A and s
//   bus   : slave side of simp_pipe_csa_n_if (in = operands, s = sum)
// Stage 1 reduces NUM_OPS operands to a carry-save pair with a tree of
// csa_3to2 compressors and registers it in bank A. Stage 2 performs the single
// carry-propagate add into s. Latency 2 edges, one result per cycle,
// arithmetic modulo 2^WIDTH.
// ----------------------------------------------------------------------------
module simp_pipe_csa_n
    import simp_pipe_csa_n_pkg::*;
#(
    parameter int NUM_OPS = INPUT_VEC_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    simp_pipe_csa_n_if.slave  bus
);

    localparam int LEVELS   = num_levels(NUM_OPS);
    localparam int FINAL    = level_base(NUM_OPS, LEVELS);
    localparam int FINAL_N  = level_count(NUM_OPS, LEVELS);
    localparam int NODES    = FINAL + FINAL_N;

    // Every tree level is packed back-to-back in one flat array, so each node
    // is driven exactly once and consumed exactly once.
    operand_t node [NODES];

    cs_pair_t cs_next;
    cs_pair_t bank_a;
    operand_t s_q;

    for (genvar j = 0; j < NUM_OPS; j++) begin : g_in
        assign node[j] = bus.in[j];
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_level
        localparam int CNT    = level_count(NUM_OPS, l);
        localparam int SRC    = level_base(NUM_OPS, l);
        localparam int DST    = level_base(NUM_OPS, l + 1);
        localparam int GROUPS = CNT / 3;

        for (genvar g = 0; g < GROUPS; g++) begin : g_csa
            csa_3to2 u_csa (
                .a     (node[SRC + 3*g]),
                .b     (node[SRC + 3*g + 1]),
                .c     (node[SRC + 3*g + 2]),
                .sum   (node[DST + 2*g]),
                .carry (node[DST + 2*g + 1])
            );
        end

        // Leftover operands skip this level unchanged.
        for (genvar r = 0; r < CNT % 3; r++) begin : g_pass
            assign node[DST + 2*GROUPS + r] = node[SRC + 3*GROUPS + r];
        end
    end

    if (FINAL_N == 1) begin : g_final_one
        assign cs_next.sum   = node[FINAL];
        assign cs_next.carry = '0;
    end else begin : g_final_two
        assign cs_next.sum   = node[FINAL];
        assign cs_next.carry = node[FINAL + 1];
    end

    // NOTE: pipeline state uses non-blocking assignments so every stage reads
    // the previous-cycle value of the stage before it, and the async reset
    // clears both banks so no stale in-flight result survives a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_a <= '0;
            s_q    <= '0;
        end else begin
            bank_a <= cs_next;
            s_q    <= bank_a.sum + bank_a.carry;
        end
    end

    assign bus.s = s_q;

endmodule

// File: tb/tb_simp_pipe_csa_n.sv
// ----------------------------------------------------------------------------
// tb_simp_pipe_csa_n
// Directed bench for simp_pipe_csa_n: one 8-operand instance plus 1/2/3/5
// operand instances for the operand-count sweep. Inputs change and outputs
// are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_simp_pipe_csa_n;
    import simp_pipe_csa_n_pkg::*;

    typedef logic [7:0][WIDTH-1:0] vec_t;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_err;

    simp_pipe_csa_n_if #(.NUM_OPS(8)) bus8 ();
    simp_pipe_csa_n_if #(.NUM_OPS(1)) bus1 ();
    simp_pipe_csa_n_if #(.NUM_OPS(2)) bus2 ();
    simp_pipe_csa_n_if #(.NUM_OPS(3)) bus3 ();
    simp_pipe_csa_n_if #(.NUM_OPS(5)) bus5 ();

    simp_pipe_csa_n #(.NUM_OPS(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    simp_pipe_csa_n #(.NUM_OPS(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    simp_pipe_csa_n #(.NUM_OPS(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
    simp_pipe_csa_n #(.NUM_OPS(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));
    simp_pipe_csa_n #(.NUM_OPS(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: observed no end of test, required finish before 50000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input operand_t observed, input operand_t expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference: plain integer sum of all eight operands, wrapped to WIDTH.
    function automatic operand_t model_sum(input vec_t v);
        logic [31:0] acc;
        acc = '0;
        for (int j = 0; j < 8; j++) begin
            acc += 32'(v[j]);
        end
        return acc[WIDTH-1:0];
    endfunction

    // Drive a vector, let one rising edge sample it, return on the falling edge.
    task automatic step(input vec_t v);
        bus8.in = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t fill(input operand_t x);
        vec_t v;
        for (int j = 0; j < 8; j++) v[j] = x;
        return v;
    endfunction

    initial begin
        vec_t     v;
        operand_t prev;

        n_cmp = 0;
        n_err = 0;

        // Sweep instances see constant in[j] = j + 1 for the whole run.
        bus1.in[0] = 16'd1;
        for (int j = 0; j < 2; j++) bus2.in[j] = 16'(j + 1);
        for (int j = 0; j < 3; j++) bus3.in[j] = 16'(j + 1);
        for (int j = 0; j < 5; j++) bus5.in[j] = 16'(j + 1);

        // Reset held with random inputs.
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int j = 0; j < 8; j++) v[j] = 16'($urandom);
            step(v);
            check("reset_hold", bus8.s, 16'h0000);
        end
        check("reset_sweep1", bus1.s, 16'h0000);
        check("reset_sweep5", bus5.s, 16'h0000);

        // Release with all operands = 1: 0 after first edge, 8 after second.
        bus8.in = fill(16'h0001);
        rst_n   = 1'b1;
        step(fill(16'h0001));
        check("release_edge1", bus8.s, 16'h0000);
        step(fill(16'h0001));
        check("release_edge2", bus8.s, 16'h0008);
        step(fill(16'h0001));
        check("hold_const", bus8.s, 16'h0008);

        // Back-to-back directed vectors, one result per cycle.
        for (int j = 0; j < 8; j++) v[j] = 16'(j + 1);             // sum 0x0024
        step(v);
        check("pipe_prev_const", bus8.s, 16'h0008);
        step(fill(16'h1000));                                       // sum 0x8000
        check("pipe_v0", bus8.s, 16'h0024);
        v[0] = 16'h0001; v[1] = 16'h0010; v[2] = 16'h0100; v[3] = 16'h1000;
        v[4] = 16'h0002; v[5] = 16'h0020; v[6] = 16'h0200; v[7] = 16'h2000;
        step(v);                                                    // sum 0x3333
        check("pipe_v1", bus8.s, 16'h8000);
        step(fill(16'hFFFF));                                       // 8*FFFF -> FFF8
        check("pipe_v2", bus8.s, 16'h3333);
        for (int j = 0; j < 8; j++) v[j] = (j % 2 == 0) ? 16'hAAAA : 16'h5555;
        step(v);                                                    // 4*FFFF -> FFFC
        check("wrap_all_ones", bus8.s, 16'hFFF8);
        step(fill(16'h0000));
        check("wrap_alt", bus8.s, 16'hFFFC);
        step(fill(16'h0000));
        check("zeros", bus8.s, 16'h0000);

        // Random stream against the integer model, two-edge latency.
        prev = '0;
        for (int i = 0; i < 50; i++) begin
            for (int j = 0; j < 8; j++) v[j] = 16'($urandom);
            step(v);
            if (i > 0) check($sformatf("rand_%0d", i), bus8.s, prev);
            prev = model_sum(v);
        end

        // Mid-stream reset with the pipeline full.
        for (int j = 0; j < 8; j++) v[j] = 16'h0101;                // sum 0x0808
        step(v);
        step(fill(16'h0300));                                       // sum 0x1800
        check("pre_reset_full", bus8.s, 16'h0808);
        #1 rst_n = 1'b0;
        #1 check("async_clear", bus8.s, 16'h0000);
        #1 rst_n = 1'b1;
        #1 check("post_release_idle", bus8.s, 16'h0000);
        for (int j = 0; j < 8; j++) v[j] = 16'(16'h0010 * (j + 1)); // sum 0x0240
        step(v);
        check("no_stale_data", bus8.s, 16'h0000);
        step(fill(16'h0000));
        check("first_after_reset", bus8.s, 16'h0240);

        // Operand-count sweep: long since settled on constant j + 1 inputs.
        check("sweep_n1", bus1.s, 16'd1);
        check("sweep_n2", bus2.s, 16'd3);
        check("sweep_n3", bus3.s, 16'd6);
        check("sweep_n5", bus5.s, 16'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/simp_pipe_csa_n.md
# simp_pipe_csa_n

Pipelined multi-operand adder for the DPE datapath. Each clock it sums all INPUT_VEC_LEN operands of a packed input vector using a carry-save (3:2 compressor) reduction tree, then a single carry-propagate add, and returns the WIDTH-bit result modulo 2^WIDTH. It sits after the dot-product multiplier stage and reduces partial products to one sum per cycle, with fixed latency and full throughput.

## Interface
Parameters, taken from the shared DPE parameter package rather than declared locally:
- INPUT_VEC_LEN, default 8: number of operands summed per cycle; must be at least 1.
- WIDTH, default 16: bit width of each operand and of the result.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in  input  [INPUT_VEC_LEN-1:0][WIDTH-1:0]  packed operand vector; unsigned operands.
- s  output  WIDTH  registered sum of the operands sampled 2 cycles earlier, modulo 2^WIDTH.

## Operation
- Every rising edge, `in` is sampled unconditionally. There is no valid or enable handshake, and the block accepts a new vector every cycle.
- Stage 1 (combinational, from `in` to register bank A):
  - Reduce INPUT_VEC_LEN operands to two vectors, sum and carry, using a tree of 3:2 compressors.
  - At each level, group operands in threes. Any 1 or 2 leftover operands pass unchanged to the next level.
  - Carry vectors are shifted left by 1 and truncated to WIDTH bits. Any bit at position WIDTH or above is discarded.
  - Small operand counts:
    - INPUT_VEC_LEN = 1: sum = in[0], carry = 0.
    - INPUT_VEC_LEN = 2: sum = in[0], carry = in[1].
  - The sum and carry vectors are registered into bank A.
- Stage 2: s <= A.sum + A.carry, truncated to WIDTH bits.
- Arithmetic is unsigned and wraps modulo 2^WIDTH. Overflow is neither flagged nor saturated.
- Result: s at cycle t+2 equals (Σ in[j] sampled at edge t) mod 2^WIDTH.

## Timing
- Latency is exactly 2 clock edges from `in` sampling to `s` update, independent of INPUT_VEC_LEN.
- Throughput is one result per cycle.
- Reset:
  - Asserting rst_n low immediately clears bank A and `s` to 0, independent of clk.
  - While rst_n is low, `s` = 0.
- Reset release:
  - The first edge after release samples `in`.
  - The corresponding sum appears on `s` at the second edge.
  - Until then, `s` shows the sum of the zeroed bank A, which is 0.
- Reset asserted mid-stream: all in-flight results are discarded. After release, no stale data appears on `s`.
- Inputs held constant: `s` settles to their sum after 2 edges and stays there.
- Timing target: the compressor tree depth (about log1.5(INPUT_VEC_LEN) full-adder delays) plus register setup must fit in one cycle.
  - If it does not, insert extra register levels and document the new latency. The default configuration must keep latency 2.

## Structure
- The shared package holds INPUT_VEC_LEN, WIDTH, and an operand vector typedef (WIDTH-bit unsigned).
- Sub-module csa_3to2:
  - Inputs: three WIDTH-bit vectors.
  - Outputs: sum = a^b^c, and carry = majority(a, b, c) shifted left by 1 within WIDTH bits.
  - The top level builds the reduction tree with generate loops over csa_3to2 instances.
- The top level holds bank A (2×WIDTH flops) and the output register (WIDTH flops).

## Test plan
- Reset:
  - Hold rst_n=0 with random `in` → `s` = 0 throughout.
  - Release reset with `in` = all 1s (INPUT_VEC_LEN=8, WIDTH=16) → `s` = 0 until the 2nd edge after release, then 8.
- Latency/throughput: drive vectors V0, V1, V2 on consecutive cycles → `s` shows sum(V0), sum(V1), sum(V2) on edges 2, 3, 4, each for one cycle.
- Wrap-around: every in[j] = 16'hFFFF with 8 operands → `s` = (8×65535) mod 65536 = 16'hFFF8.
- Random stream: 50 consecutive cycles of $urandom vectors → each `s` equals the scoreboard sum of the vector from 2 cycles earlier, mod 2^16. The scoreboard is cleared per vector, not accumulated.
- Mid-stream reset: assert rst_n low for 1 ns while the pipeline is full → `s` = 0 asynchronously. After release, the first non-zero `s` is the sum of the first vector sampled after release.
- Parameter sweep: INPUT_VEC_LEN ∈ {1, 2, 3, 5} with in[j] = j+1 → `s` = 1, 3, 6, 15 respectively, after 2 edges.
